// File: rtl/cache_set_array.sv
// Set-associative tag/data/state array with round-robin victim selection and an invalidation sweep.
// Optional macro CACHE_SET_ARRAY_DIRTY_EN adds per-line dirty bits set by writes.
module cache_set_array #(
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_WIDTH = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 20,
    localparam int WAY_WIDTH  = $clog2(NUM_WAYS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [1:0]              i_req_op,
    input  logic [INDEX_WIDTH-1:0]  i_req_index,
    input  logic [TAG_WIDTH-1:0]    i_req_tag,
    input  logic [WAY_WIDTH-1:0]    i_req_way,
    input  logic [DATA_WIDTH/8-1:0] i_req_ben,
    input  logic [DATA_WIDTH-1:0]   i_req_data,
    output logic                    o_rsp_valid,
    output logic                    o_rsp_hit,
    output logic [WAY_WIDTH-1:0]    o_rsp_way,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic [WAY_WIDTH-1:0]    o_rsp_victim_way,
    output logic                    o_rsp_victim_valid,
    output logic [TAG_WIDTH-1:0]    o_rsp_victim_tag,
    output logic                    o_rsp_victim_dirty,
    output logic                    o_busy
);
    localparam int NUM_SETS  = 1 << INDEX_WIDTH;
    localparam int BEN_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {ST_SWEEP, ST_READY} state_t;

    typedef struct packed {
        logic                  hit;
        logic [WAY_WIDTH-1:0]  way;
        logic [DATA_WIDTH-1:0] data;
        logic [WAY_WIDTH-1:0]  vic_way;
        logic                  vic_valid;
        logic [TAG_WIDTH-1:0]  vic_tag;
        logic                  vic_dirty;
    } rsp_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    rsp_t                   rsp_q, rsp_d, rsp_cur;

    logic accept, do_lookup, do_write, do_fill, do_inval;

    assign o_req_ready = (state_q == ST_READY) && !i_flush;
    assign o_busy      = (state_q == ST_SWEEP);
    assign accept      = i_req_valid && o_req_ready;
    assign do_lookup   = accept && (i_req_op == 2'b00);
    assign do_write    = accept && (i_req_op == 2'b01);
    assign do_fill     = accept && (i_req_op == 2'b10);
    assign do_inval    = accept && (i_req_op == 2'b11);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = ST_SWEEP;
            cnt_d   = '0;
        end else if (state_q == ST_SWEEP) begin
            if (&cnt_q) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Per-set state bits live in plain flops so the sweep can clear a whole set per cycle.
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [WAY_WIDTH-1:0] ptr_q   [NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_snap_q;
    logic [WAY_WIDTH-1:0] ptr_snap_q;
    logic [TAG_WIDTH-1:0] tag_cmp_q;
    logic [NUM_WAYS-1:0]  dirty_snap;

    always_ff @(posedge clk) begin
        if (state_q == ST_SWEEP) begin
            valid_q[cnt_q] <= '0;
            ptr_q[cnt_q]   <= '0;
        end else if (do_fill) begin
            valid_q[i_req_index][i_req_way] <= 1'b1;
            ptr_q[i_req_index]              <= i_req_way + 1'b1;
        end else if (do_inval) begin
            valid_q[i_req_index][i_req_way] <= 1'b0;
        end
        if (do_lookup) begin
            valid_snap_q <= valid_q[i_req_index];
            ptr_snap_q   <= ptr_q[i_req_index];
            tag_cmp_q    <= i_req_tag;
        end
    end

`ifdef CACHE_SET_ARRAY_DIRTY_EN
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_snap_q;

    always_ff @(posedge clk) begin
        if (state_q == ST_SWEEP) begin
            dirty_q[cnt_q] <= '0;
        end else if (do_write) begin
            dirty_q[i_req_index][i_req_way] <= 1'b1;
        end else if (do_fill || do_inval) begin
            dirty_q[i_req_index][i_req_way] <= 1'b0;
        end
        if (do_lookup) begin
            dirty_snap_q <= dirty_q[i_req_index];
        end
    end
    assign dirty_snap = dirty_snap_q;
`else
    assign dirty_snap = '0;
`endif

    logic [NUM_WAYS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0]  rd_tag;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];
            logic [TAG_WIDTH-1:0]  tag_mem  [NUM_SETS];
            logic [DATA_WIDTH-1:0] data_rd_q;
            logic [TAG_WIDTH-1:0]  tag_rd_q;
            logic                  way_sel;

            assign way_sel = (i_req_way == WAY_WIDTH'(gi));

            always_ff @(posedge clk) begin
                for (int b = 0; b < BEN_WIDTH; b++) begin
                    if (way_sel && (do_fill || (do_write && i_req_ben[b]))) begin
                        data_mem[i_req_index][b*8 +: 8] <= i_req_data[b*8 +: 8];
                    end
                end
                if (way_sel && do_fill) begin
                    tag_mem[i_req_index] <= i_req_tag;
                end
                if (do_lookup) begin
                    data_rd_q <= data_mem[i_req_index];
                    tag_rd_q  <= tag_mem[i_req_index];
                end
            end

            assign rd_data[gi] = data_rd_q;
            assign rd_tag[gi]  = tag_rd_q;
        end
    endgenerate

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        rsp_cur           = '0;
        rsp_cur.vic_way   = ptr_snap_q;
        rsp_cur.vic_valid = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_snap_q[w] && (rd_tag[w] == tag_cmp_q)) begin
                rsp_cur.hit = 1'b1;
                rsp_cur.way = WAY_WIDTH'(w);
            end
            if (!valid_snap_q[w]) begin
                rsp_cur.vic_valid = 1'b0;
                rsp_cur.vic_way   = WAY_WIDTH'(w);
            end
        end
        rsp_cur.data      = rsp_cur.hit ? rd_data[rsp_cur.way] : '0;
        rsp_cur.vic_tag   = rd_tag[rsp_cur.vic_way];
        rsp_cur.vic_dirty = dirty_snap[rsp_cur.vic_way];
    end

    assign rsp_valid_d = do_lookup;
    assign rsp_d       = rsp_valid_q ? rsp_cur : rsp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SWEEP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign o_rsp_valid        = rsp_valid_q;
    assign o_rsp_hit          = rsp_d.hit;
    assign o_rsp_way          = rsp_d.way;
    assign o_rsp_data         = rsp_d.data;
    assign o_rsp_victim_way   = rsp_d.vic_way;
    assign o_rsp_victim_valid = rsp_d.vic_valid;
    assign o_rsp_victim_tag   = rsp_d.vic_tag;
    assign o_rsp_victim_dirty = rsp_d.vic_dirty;
endmodule

// File: tb/tb_cache_set_array.sv
// Randomized self-checking bench for cache_set_array against an array-based reference model.
module tb_cache_set_array;
    localparam int NW = 4, IW = 7, DW = 32, TW = 20, WW = 2, BW = 4, NS = 128;
`ifdef CACHE_SET_ARRAY_DIRTY_EN
    localparam bit DIRTY_EN = 1'b1;
`else
    localparam bit DIRTY_EN = 1'b0;
`endif
    localparam logic [1:0] OP_LK = 2'b00, OP_WR = 2'b01, OP_FL = 2'b10, OP_IN = 2'b11;

    logic          clk = 1'b0, reset = 1'b1, i_flush = 1'b0, i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_op = '0;
    logic [IW-1:0] i_req_index = '0;
    logic [TW-1:0] i_req_tag = '0;
    logic [WW-1:0] i_req_way = '0;
    logic [BW-1:0] i_req_ben = '0;
    logic [DW-1:0] i_req_data = '0;
    logic          o_rsp_valid, o_rsp_hit, o_rsp_victim_valid, o_rsp_victim_dirty, o_busy;
    logic [WW-1:0] o_rsp_way, o_rsp_victim_way;
    logic [DW-1:0] o_rsp_data;
    logic [TW-1:0] o_rsp_victim_tag;

    cache_set_array #(.NUM_WAYS(NW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready), .i_req_op(i_req_op), .i_req_index(i_req_index),
        .i_req_tag(i_req_tag), .i_req_way(i_req_way), .i_req_ben(i_req_ben),
        .i_req_data(i_req_data), .o_rsp_valid(o_rsp_valid), .o_rsp_hit(o_rsp_hit),
        .o_rsp_way(o_rsp_way), .o_rsp_data(o_rsp_data), .o_rsp_victim_way(o_rsp_victim_way),
        .o_rsp_victim_valid(o_rsp_victim_valid), .o_rsp_victim_tag(o_rsp_victim_tag),
        .o_rsp_victim_dirty(o_rsp_victim_dirty), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays of architectural line state.
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    int            m_ptr   [NS];
    logic [DW-1:0] m_data  [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];

    bit            exp_hit, exp_vvalid, exp_vdirty;
    int            exp_way, exp_vway;
    logic [DW-1:0] exp_data;
    logic [TW-1:0] exp_vtag;

    logic          obs_valid, obs_hit, obs_vvalid, obs_vdirty, obs_ready;
    logic [WW-1:0] obs_way, obs_vway;
    logic [DW-1:0] obs_data;
    logic [TW-1:0] obs_vtag;

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic void model_lookup(input int idx, input logic [TW-1:0] tag);
        bit found_inv;
        exp_hit = 1'b0; exp_way = 0; exp_data = '0; found_inv = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (!exp_hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
                exp_hit = 1'b1; exp_way = w; exp_data = m_data[idx][w];
            end
            if (!found_inv && !m_valid[idx][w]) begin
                found_inv = 1'b1; exp_vway = w;
            end
        end
        if (!found_inv) exp_vway = m_ptr[idx];
        exp_vvalid = !found_inv;
        exp_vtag   = m_tag[idx][exp_vway];
        exp_vdirty = m_dirty[idx][exp_vway];
    endfunction

    // Drives one request at a negedge, applies it to the model, samples the DUT one cycle later.
    task automatic issue(input logic [1:0] op, input int idx, input logic [TW-1:0] tag,
                         input int way, input logic [BW-1:0] ben, input logic [DW-1:0] data);
        i_req_valid = 1'b1; i_req_op = op; i_req_index = IW'(idx); i_req_tag = tag;
        i_req_way = WW'(way); i_req_ben = ben; i_req_data = data;
        #1 obs_ready = o_req_ready;
        case (op)
            OP_LK: model_lookup(idx, tag);
            OP_WR: begin
                for (int b = 0; b < BW; b++)
                    if (ben[b]) m_data[idx][way][b*8 +: 8] = data[b*8 +: 8];
                if (DIRTY_EN) m_dirty[idx][way] = 1'b1;
            end
            OP_FL: begin
                m_data[idx][way] = data; m_tag[idx][way] = tag;
                m_valid[idx][way] = 1'b1; m_dirty[idx][way] = 1'b0;
                m_ptr[idx] = (way + 1) % NW;
            end
            default: begin
                m_valid[idx][way] = 1'b0; m_dirty[idx][way] = 1'b0;
            end
        endcase
        @(posedge clk); @(negedge clk);
        obs_valid = o_rsp_valid; obs_hit = o_rsp_hit; obs_way = o_rsp_way; obs_data = o_rsp_data;
        obs_vway = o_rsp_victim_way; obs_vvalid = o_rsp_victim_valid;
        obs_vtag = o_rsp_victim_tag; obs_vdirty = o_rsp_victim_dirty;
    endtask

    task automatic idle(input int n);
        i_req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Counts consecutive negedge samples with o_busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int c = 0; c < 1000 && o_busy; c++) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        #3;
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", o_busy); end
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", o_req_ready); end
        total++; if ({o_rsp_valid, o_rsp_hit, o_rsp_data, o_rsp_victim_way, o_rsp_victim_valid} !== '0)
            begin bad++; $display("FAIL reset_rsp got=%b/%b/%h/%0d/%b want=0", o_rsp_valid, o_rsp_hit, o_rsp_data, o_rsp_victim_way, o_rsp_victim_valid); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        count_busy(n);
        total++; if (n != 128) begin bad++; $display("FAIL reset_sweep_len got=%0d want=128", n); end
        total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", o_req_ready); end
        issue(OP_LK, 77, 20'h0ABCD, 0, '0, '0);
        idle(1);
        total++; if (obs_valid !== 1'b1 || obs_hit !== 1'b0) begin bad++; $display("FAIL reset_lookup valid/hit got=%b/%b want=1/0", obs_valid, obs_hit); end
        total++; if (obs_vway !== 2'd0 || obs_vvalid !== 1'b0) begin bad++; $display("FAIL reset_victim got=%0d/%b want=0/0", obs_vway, obs_vvalid); end
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_pulse got=%b want=0", o_rsp_valid); end
    endtask

    task automatic test_fill_hit();
        issue(OP_FL, 5, 20'h12345, 2, '0, 32'hDEADBEEF);
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL fill_no_rsp got=%b want=0", obs_valid); end
        issue(OP_LK, 5, 20'h12345, 0, '0, '0);
        idle(1);
        total++; if (obs_valid !== 1'b1 || obs_hit !== 1'b1) begin bad++; $display("FAIL fill_hit valid/hit got=%b/%b want=1/1", obs_valid, obs_hit); end
        total++; if (obs_way !== 2'd2 || obs_data !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_hit way/data got=%0d/%h want=2/deadbeef", obs_way, obs_data); end
    endtask

    task automatic test_victim_rr();
        for (int w = 0; w < NW; w++) issue(OP_FL, 9, TW'(w + 1), w, '0, $urandom);
        issue(OP_LK, 9, 20'd7, 0, '0, '0);
        total++; if (obs_hit !== 1'b0 || obs_vway !== 2'd0 || obs_vvalid !== 1'b1 || obs_vtag !== 20'd1)
            begin bad++; $display("FAIL rr_victim hit/way/valid/tag got=%b/%0d/%b/%h want=0/0/1/1", obs_hit, obs_vway, obs_vvalid, obs_vtag); end
        issue(OP_FL, 9, 20'd5, 0, '0, $urandom);
        issue(OP_LK, 9, 20'd7, 0, '0, '0);
        idle(1);
        total++; if (obs_vway !== 2'd1 || obs_vtag !== 20'd2) begin bad++; $display("FAIL rr_advance way/tag got=%0d/%h want=1/2", obs_vway, obs_vtag); end
    endtask

    task automatic test_write_ben();
        issue(OP_FL, 3, 20'h00033, 1, '0, 32'h11111111);
        issue(OP_WR, 3, 20'h0, 1, 4'b0011, 32'hAAAA5555);
        issue(OP_LK, 3, 20'h00033, 0, '0, '0);
        total++; if (obs_hit !== 1'b1 || obs_data !== 32'h11115555) begin bad++; $display("FAIL ben_data hit/data got=%b/%h want=1/11115555", obs_hit, obs_data); end
        issue(OP_IN, 3, '0, 0, '0, '0);
        issue(OP_IN, 3, '0, 2, '0, '0);
        issue(OP_IN, 3, '0, 3, '0, '0);
        issue(OP_LK, 3, 20'h00099, 0, '0, '0);
        total++; if (obs_hit !== 1'b0 || obs_vway !== 2'd0 || obs_vvalid !== 1'b0) begin bad++; $display("FAIL inval_victim hit/way/valid got=%b/%0d/%b want=0/0/0", obs_hit, obs_vway, obs_vvalid); end
        issue(OP_FL, 3, 20'h00040, 2, '0, $urandom);
        issue(OP_FL, 3, 20'h00041, 3, '0, $urandom);
        issue(OP_FL, 3, 20'h00042, 0, '0, $urandom);
        issue(OP_LK, 3, 20'h00099, 0, '0, '0);
        idle(2);
        total++; if (obs_vway !== 2'd1 || obs_vvalid !== 1'b1 || obs_vdirty !== DIRTY_EN) begin bad++; $display("FAIL dirty_victim way/valid/dirty got=%0d/%b/%b want=1/1/%b", obs_vway, obs_vvalid, obs_vdirty, DIRTY_EN); end
        // Response fields must hold while o_rsp_valid is low.
        total++; if (o_rsp_valid !== 1'b0 || o_rsp_victim_way !== obs_vway || o_rsp_victim_tag !== obs_vtag) begin bad++; $display("FAIL hold valid/way/tag got=%b/%0d/%h want=0/%0d/%h", o_rsp_valid, o_rsp_victim_way, o_rsp_victim_tag, obs_vway, obs_vtag); end
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(3));
            issue(op, 20 + $urandom_range(3), TW'($urandom_range(1, 5)), $urandom_range(NW - 1), 4'($urandom), $urandom);
            if (!obs_ready) begin total++; bad++; $display("FAIL rnd_ready i=%0d got=0 want=1", i); end
            if (op == OP_LK) begin
                total++;
                if (obs_valid !== 1'b1 || obs_hit !== exp_hit || obs_vway !== WW'(exp_vway) || obs_vvalid !== exp_vvalid
                    || obs_vdirty !== exp_vdirty || obs_data !== exp_data || (exp_hit && obs_way !== WW'(exp_way))
                    || (exp_vvalid && obs_vtag !== exp_vtag)) begin
                    bad++;
                    $display("FAIL rnd_lookup i=%0d got v%b h%b w%0d d%h vw%0d vv%b vt%h vd%b want v1 h%b w%0d d%h vw%0d vv%b vt%h vd%b",
                             i, obs_valid, obs_hit, obs_way, obs_data, obs_vway, obs_vvalid, obs_vtag, obs_vdirty,
                             exp_hit, exp_way, exp_data, exp_vway, exp_vvalid, exp_vtag, exp_vdirty);
                end
            end else begin
                total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rnd_spurious_rsp i=%0d got=1 want=0", i); end
            end
            if ($urandom_range(3) == 0) idle(1);
        end
        idle(1);
    endtask

    task automatic test_flush();
        int n;
        for (int k = 0; k < 4; k++) issue(OP_FL, 30 + k, 20'h00777, 0, '0, $urandom);
        issue(OP_LK, 30, 20'h00777, 0, '0, '0);
        i_req_valid = 1'b0; i_flush = 1'b1;
        total++; if (obs_hit !== 1'b1) begin bad++; $display("FAIL flush_preflush_hit got=%b want=1", obs_hit); end
        #1;
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", o_req_ready); end
        @(negedge clk);
        i_flush = 1'b0;
        model_clear();
        count_busy(n);
        total++; if (n != 128) begin bad++; $display("FAIL flush_sweep_len got=%0d want=128", n); end
        for (int k = 0; k < 4; k++) begin
            issue(OP_LK, 30 + k, 20'h00777, 0, '0, '0);
            total++; if (obs_hit !== 1'b0 || obs_vvalid !== 1'b0 || obs_vway !== 2'd0) begin bad++; $display("FAIL flush_miss idx=%0d hit/vvalid/vway got=%b/%b/%0d want=0/0/0", 30 + k, obs_hit, obs_vvalid, obs_vway); end
        end
        idle(1);
    endtask

    task automatic test_flush_midsweep();
        int n;
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        n = 0;
        for (int c = 0; c < 1000 && o_busy; c++) begin
            n++;
            i_flush = (n == 61);
            @(negedge clk);
        end
        i_flush = 1'b0;
        model_clear();
        total++; if (n != 189) begin bad++; $display("FAIL flush_restart_len got=%0d want=189", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit spurious;
        issue(OP_FL, 44, 20'h00ABC, 3, '0, 32'hCAFEF00D);
        issue(OP_LK, 44, 20'h00ABC, 0, '0, '0);
        total++; if (obs_hit !== 1'b1 || obs_data !== 32'hCAFEF00D) begin bad++; $display("FAIL pre_reset_hit hit/data got=%b/%h want=1/cafef00d", obs_hit, obs_data); end
        // Another lookup is pending when reset hits; it must be discarded.
        i_req_tag = 20'h00ABC;
        #2 reset = 1'b1;
        #1;
        total++; if (o_busy !== 1'b1 || o_req_ready !== 1'b0 || o_rsp_hit !== 1'b0 || o_rsp_data !== '0 || o_rsp_victim_way !== '0)
            begin bad++; $display("FAIL async_reset busy/ready/hit/data/vway got=%b/%b/%b/%h/%0d want=1/0/0/0/0", o_busy, o_req_ready, o_rsp_hit, o_rsp_data, o_rsp_victim_way); end
        @(negedge clk);
        i_req_valid = 1'b0;
        reset = 1'b0;
        model_clear();
        spurious = 1'b0;
        n = 0;
        for (int c = 0; c < 1000 && o_busy; c++) begin
            n++;
            if (o_rsp_valid) spurious = 1'b1;
            @(negedge clk);
        end
        total++; if (spurious || n != 128) begin bad++; $display("FAIL reset_discard spurious/len got=%b/%0d want=0/128", spurious, n); end
        issue(OP_LK, 44, 20'h00ABC, 0, '0, '0);
        idle(1);
        total++; if (obs_valid !== 1'b1 || obs_hit !== 1'b0) begin bad++; $display("FAIL post_reset_miss valid/hit got=%b/%b want=1/0", obs_valid, obs_hit); end
    endtask

    initial begin
        test_reset();
        test_fill_hit();
        test_victim_rr();
        test_write_ben();
        test_random();
        test_flush();
        test_flush_midsweep();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
